phy_regfile_wb_arbiter: RTL and testbench

PHY_REGFILE_WB_ARBITER -- requirements
Module: phy_regfile_wb_arbiter

---
 rtl/phy_regfile_wb_arbiter_pkg.sv | 32 +++
 rtl/phy_regfile_wb_arbiter_rr_arbiter.sv | 35 +++
 rtl/phy_regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_phy_regfile_wb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_regfile_wb_arbiter_pkg.sv
// Shared definitions for the physical register file writeback path: widths, source indices
// and the registered commit record.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package phy_regfile_wb_arbiter_pkg;

    localparam int unsigned PHY_REG_W = `PHYSICAL_REG_NUM_WIDTH;
    localparam int unsigned REG_VAL_W = `REG_VAL_WIDTH;

    // Writeback requester indices.
    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_LSU = 1;
    localparam int unsigned WB_SRC_AUX = 2;
    localparam int unsigned WB_NUM_SRC = 3;

    typedef struct packed {
        logic                 en;
        logic [PHY_REG_W-1:0] phy_reg;
        logic [REG_VAL_W-1:0] val;
    } wb_commit_t;

    // Index width for a pool of n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phy_regfile_wb_arbiter_rr_arbiter.sv
// Round-robin selector: grants the first asserted request at or after ptr, wrapping at NUM_REQ.
// Purely combinational so it can be reused by issue logic.
module rr_arbiter
    import phy_regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [PTR_W-1:0]   gnt_idx_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/phy_regfile_wb_arbiter.sv
// Writeback arbiter for the physical register file: one round-robin grant per cycle, a
// registered commit port and a saturating multi-request statistics counter.
module phy_regfile_wb_arbiter
    import phy_regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC   = WB_NUM_SRC,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       flush_i,
    input  logic [NUM_SRC-1:0]                         req_valid_i,
    input  logic [NUM_SRC*`PHYSICAL_REG_NUM_WIDTH-1:0] req_phy_reg_i,
    input  logic [NUM_SRC*`REG_VAL_WIDTH-1:0]          req_val_i,
    output logic [NUM_SRC-1:0]                         req_ready_o,
    output logic                                       commit_wr_en_o,
    output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]         wr_commit_reg_o,
    output logic [`REG_VAL_WIDTH-1:0]                  commit_wr_val_o,
    output logic [CNT_WIDTH-1:0]                       wb_conflict_cnt_o
);

    localparam int unsigned PtrW = idx_width(NUM_SRC);

    logic [PtrW-1:0]      ptr_q, ptr_d;
    wb_commit_t           commit_q, commit_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [NUM_SRC-1:0]   gnt;
    logic                 gnt_valid;
    logic [PtrW-1:0]      gnt_idx;
    logic                 block;
    logic                 xfer;
    logic [PHY_REG_W-1:0] sel_reg;
    logic [REG_VAL_W-1:0] sel_val;
    logic                 multi_req;

    rr_arbiter #(
        .NUM_REQ (NUM_SRC),
        .PTR_W   (PtrW)
    ) u_rr_arbiter (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Reset and flush both suppress the handshake; nothing may transfer while either is high.
    assign block       = reset | flush_i;
    assign req_ready_o = block ? '0 : gnt;
    assign xfer        = gnt_valid & ~block;

    // One-hot mux of the granted source's payload.
    always_comb begin
        sel_reg = '0;
        sel_val = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                sel_reg = sel_reg | req_phy_reg_i[i*PHY_REG_W +: PHY_REG_W];
                sel_val = sel_val | req_val_i[i*REG_VAL_W +: REG_VAL_W];
            end
        end
    end

    always_comb begin
        int unsigned n_valid;
        n_valid = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            n_valid = n_valid + 32'(req_valid_i[i]);
        end
        multi_req = (n_valid >= 2);
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == PtrW'(NUM_SRC - 1)) ? '0 : gnt_idx + PtrW'(1);
        end
    end

    // Register 0 is hardwired to zero: the transfer is accepted but never written.
    always_comb begin
        commit_d.en      = xfer && (sel_reg != '0);
        commit_d.phy_reg = commit_q.phy_reg;
        commit_d.val     = commit_q.val;
        if (commit_d.en) begin
            commit_d.phy_reg = sel_reg;
            commit_d.val     = sel_val;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!flush_i && multi_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            commit_q <= '0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign commit_wr_en_o    = commit_q.en;
    assign wr_commit_reg_o   = commit_q.phy_reg;
    assign commit_wr_val_o   = commit_q.val;
    assign wb_conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_phy_regfile_wb_arbiter.sv
// Self-checking bench for phy_regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model.
module tb_phy_regfile_wb_arbiter;
    import phy_regfile_wb_arbiter_pkg::*;

    localparam int NSRC = 3;
    localparam int RW   = `PHYSICAL_REG_NUM_WIDTH;
    localparam int VW   = `REG_VAL_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 tb_flush = 1'b0;
    logic [NSRC-1:0]      tb_valid = '0;
    logic [NSRC*RW-1:0]   tb_reg = '0;
    logic [NSRC*VW-1:0]   tb_val = '0;

    logic [NSRC-1:0]      ready, sat_ready;
    logic                 en, sat_en;
    logic [RW-1:0]        wreg, sat_wreg;
    logic [VW-1:0]        wval, sat_wval;
    logic [15:0]          cnt;
    logic [1:0]           sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int            m_ptr;
    logic          m_en;
    logic [RW-1:0] m_reg;
    logic [VW-1:0] m_val;
    int            m_cnt, m_cnt2;
    logic [NSRC-1:0] exp_ready;

    phy_regfile_wb_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (tb_flush),
        .req_valid_i       (tb_valid),
        .req_phy_reg_i     (tb_reg),
        .req_val_i         (tb_val),
        .req_ready_o       (ready),
        .commit_wr_en_o    (en),
        .wr_commit_reg_o   (wreg),
        .commit_wr_val_o   (wval),
        .wb_conflict_cnt_o (cnt)
    );

    phy_regfile_wb_arbiter #(.CNT_WIDTH(2)) dut_sat (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (tb_flush),
        .req_valid_i       (tb_valid),
        .req_phy_reg_i     (tb_reg),
        .req_val_i         (tb_val),
        .req_ready_o       (sat_ready),
        .commit_wr_en_o    (sat_en),
        .wr_commit_reg_o   (sat_wreg),
        .commit_wr_val_o   (sat_wval),
        .wb_conflict_cnt_o (sat_cnt)
    );

    always #5 clk = ~clk;

    function automatic int pick();
        if (reset || tb_flush) return -1;
        for (int k = 0; k < NSRC; k++) begin
            int s;
            s = (m_ptr + k) % NSRC;
            if (tb_valid[s]) return s;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_en = 1'b0; m_reg = '0; m_val = '0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic set_src(input int s, input logic [RW-1:0] r, input logic [VW-1:0] v);
        tb_reg[s*RW +: RW] = r;
        tb_val[s*VW +: VW] = v;
    endtask

    // Apply inputs just after a falling edge and derive the expected grant.
    task automatic drive(input logic [NSRC-1:0] v, input logic f);
        int g;
        tb_valid = v;
        tb_flush = f;
        #1;
        g = pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
    endtask

    // Advance one clock and update the model with what the rising edge should capture.
    task automatic step();
        int g;
        int nv;
        @(posedge clk);
        g  = pick();
        nv = $countones(tb_valid);
        if (reset) begin
            m_reset();
        end else begin
            m_en = 1'b0;
            if (g >= 0) begin
                m_ptr = (g + 1) % NSRC;
                if (tb_reg[g*RW +: RW] != '0) begin
                    m_en  = 1'b1;
                    m_reg = tb_reg[g*RW +: RW];
                    m_val = tb_val[g*VW +: VW];
                end
            end
            if (!tb_flush && nv >= 2) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tb_valid = '0;
        tb_flush = 1'b0;
        #1;
        m_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        m_reset();
        drive(3'b111, 1'b0);
        n_checks++;
        if (ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 000", ready);
        end
        n_checks++;
        if (en !== 1'b0 || wreg !== '0 || wval !== '0 || cnt !== '0 || sat_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b reg=%0h val=%0h cnt=%0d sat=%0d expected all 0",
                     en, wreg, wval, cnt, sat_cnt);
        end
        step();
        tb_valid = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_src(WB_SRC_LSU, 6'd5, 32'hDEAD_BEEF);
        drive(3'b010, 1'b0);
        n_checks++;
        if (ready !== 3'b010) begin
            n_fail++; $display("FAIL single_ready: got %b expected 010", ready);
        end
        step();
        n_checks++;
        if (en !== 1'b1 || wreg !== 6'd5 || wval !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_commit: got en=%b reg=%0d val=%h expected en=1 reg=5 val=deadbeef",
                     en, wreg, wval);
        end
        drive(3'b111, 1'b0);
        n_checks++;
        if (ready !== 3'b100) begin
            n_fail++; $display("FAIL single_ptr: got %b expected 100", ready);
        end
        step();
        drive(3'b000, 1'b0);
        step();
    endtask

    task automatic test_round_robin();
        logic [NSRC-1:0] pat [3] = '{3'b111, 3'b110, 3'b100};
        do_reset();
        for (int s = 0; s < NSRC; s++) set_src(s, RW'(s + 1), VW'(32'h100 + s));
        for (int c = 0; c < 3; c++) begin
            drive(pat[c], 1'b0);
            n_checks++;
            if (ready !== NSRC'(1 << c)) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", c, ready, NSRC'(1 << c));
            end
            step();
            n_checks++;
            if (en !== 1'b1 || wreg !== RW'(c + 1) || wval !== VW'(32'h100 + c)) begin
                n_fail++;
                $display("FAIL rr_commit%0d: got en=%b reg=%0d val=%h expected en=1 reg=%0d val=%h",
                         c, en, wreg, wval, c + 1, 32'h100 + c);
            end
        end
        n_checks++;
        if (cnt !== 16'd2) begin
            n_fail++; $display("FAIL rr_conflict_cnt: got %0d expected 2", cnt);
        end
        drive(3'b000, 1'b0);
        step();
        n_checks++;
        if (en !== 1'b0 || wreg !== RW'(3) || wval !== VW'(32'h102)) begin
            n_fail++;
            $display("FAIL idle_hold: got en=%b reg=%0d val=%h expected en=0 reg=3 val=102",
                     en, wreg, wval);
        end
    endtask

    task automatic test_zero_dest();
        do_reset();
        set_src(WB_SRC_ALU, 6'd0, 32'd7);
        drive(3'b001, 1'b0);
        n_checks++;
        if (ready !== 3'b001) begin
            n_fail++; $display("FAIL zero_ready: got %b expected 001", ready);
        end
        step();
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++; $display("FAIL zero_no_write: got en=%b expected 0", en);
        end
        drive(3'b000, 1'b0);
        step();
    endtask

    task automatic test_flush();
        do_reset();
        set_src(WB_SRC_LSU, 6'd9, 32'h1111);
        set_src(WB_SRC_AUX, 6'd10, 32'h2222);
        set_src(WB_SRC_ALU, 6'd11, 32'h3333);
        drive(3'b010, 1'b0);
        step();
        for (int c = 0; c < 2; c++) begin
            drive(3'b111, 1'b1);
            n_checks++;
            if (ready !== 3'b000) begin
                n_fail++; $display("FAIL flush_ready%0d: got %b expected 000", c, ready);
            end
            if (c == 0) begin
                n_checks++;
                if (en !== 1'b1 || wreg !== 6'd9) begin
                    n_fail++;
                    $display("FAIL flush_prior_write: got en=%b reg=%0d expected en=1 reg=9",
                             en, wreg);
                end
            end
            step();
            n_checks++;
            if (en !== 1'b0 || cnt !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL flush_commit%0d: got en=%b cnt=%0d expected en=0 cnt=%0d",
                         c, en, cnt, m_cnt);
            end
        end
        drive(3'b111, 1'b0);
        n_checks++;
        if (ready !== 3'b100) begin
            n_fail++; $display("FAIL flush_ptr_hold: got %b expected 100", ready);
        end
        step();
        n_checks++;
        if (en !== 1'b1 || wreg !== 6'd10 || wval !== 32'h2222) begin
            n_fail++;
            $display("FAIL flush_after: got en=%b reg=%0d val=%h expected en=1 reg=10 val=2222",
                     en, wreg, wval);
        end
        drive(3'b000, 1'b0);
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        set_src(WB_SRC_ALU, 6'd1, 32'hA);
        set_src(WB_SRC_LSU, 6'd2, 32'hB);
        for (int c = 0; c < 6; c++) begin
            drive(3'b011, 1'b0);
            n_checks++;
            if (ready !== exp_ready) begin
                n_fail++; $display("FAIL sat_grant%0d: got %b expected %b", c, ready, exp_ready);
            end
            step();
            n_checks++;
            if (sat_cnt !== 2'(m_cnt2)) begin
                n_fail++; $display("FAIL sat_cnt%0d: got %0d expected %0d", c, sat_cnt, m_cnt2);
            end
        end
        n_checks++;
        if (sat_cnt !== 2'd3 || cnt !== 16'd6) begin
            n_fail++;
            $display("FAIL sat_final: got sat=%0d wide=%0d expected sat=3 wide=6", sat_cnt, cnt);
        end
        drive(3'b000, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        set_src(WB_SRC_ALU, 6'd4, 32'h4444);
        set_src(WB_SRC_LSU, 6'd9, 32'hABCD);
        drive(3'b011, 1'b0);
        step();
        drive(3'b010, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (en !== 1'b0 || wreg !== '0 || wval !== '0 || cnt !== '0 || sat_cnt !== '0 ||
            ready !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got en=%b reg=%0h val=%0h cnt=%0d sat=%0d rdy=%b expected 0",
                     en, wreg, wval, cnt, sat_cnt, ready);
        end
        m_reset();
        step();
        reset = 1'b0;
        drive(3'b000, 1'b0);
        step();
        n_checks++;
        if (en !== 1'b0) begin
            n_fail++; $display("FAIL async_no_spurious: got en=%b expected 0", en);
        end
        drive(3'b011, 1'b0);
        n_checks++;
        if (ready !== 3'b001) begin
            n_fail++; $display("FAIL async_ptr_reset: got %b expected 001", ready);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NSRC; s++) set_src(s, RW'($urandom_range(0, 7)), VW'($urandom));
            drive(NSRC'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            n_checks++;
            if (ready !== exp_ready) begin
                n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", c, ready, exp_ready);
            end
            step();
            n_checks++;
            if (en !== m_en || wreg !== m_reg || wval !== m_val || cnt !== 16'(m_cnt) ||
                sat_cnt !== 2'(m_cnt2)) begin
                n_fail++;
                $display("FAIL rand_commit@%0d: got en=%b reg=%0d val=%h cnt=%0d sat=%0d expected en=%b reg=%0d val=%h cnt=%0d sat=%0d",
                         c, en, wreg, wval, cnt, sat_cnt, m_en, m_reg, m_val, m_cnt, m_cnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_dest();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
